// File: rtl/nm_matrix_pkg.sv
// Shared constants, state encoding and slot-offset helper for the
// matrix_make / matrix_unmake pair.
package nm_matrix_pkg;

  localparam int MAX_DIM = 128;
  localparam int DATA_W  = 32;
  localparam int DIM_W   = 8;
  localparam int FLAT_W  = MAX_DIM * MAX_DIM * DATA_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // Bit offset of element (i,j) in a flat layout whose rows are 'stride' wide.
  function automatic int off(input int i, input int j, input int stride);
    return (i * stride + j) * DATA_W;
  endfunction

endpackage

// File: rtl/matrix_idx_counter.sv
// Row-major (row, col) walker over an M x N matrix. Clear loads (0,0);
// advance steps the column, wrapping into the next row at N-1, and returns
// to (0,0) after the final element so the counter idles at a known point.
module matrix_idx_counter
  import nm_matrix_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             advance,
  input  logic [DIM_W-1:0] m_dim,
  input  logic [DIM_W-1:0] n_dim,
  output logic [DIM_W-1:0] row,
  output logic [DIM_W-1:0] col,
  output logic             last
);

  logic [DIM_W-1:0] row_q, row_d;
  logic [DIM_W-1:0] col_q, col_d;
  logic [DIM_W-1:0] m_last;
  logic [DIM_W-1:0] n_last;
  logic             col_end;

  assign m_last  = m_dim - {{(DIM_W-1){1'b0}}, 1'b1};
  assign n_last  = n_dim - {{(DIM_W-1){1'b0}}, 1'b1};
  assign col_end = (col_q == n_last);
  assign last    = (row_q == m_last) && col_end;

  // Next-position selection: clear wins over advance.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clear) begin
      row_d = '0;
      col_d = '0;
    end else if (advance) begin
      if (last) begin
        row_d = '0;
        col_d = '0;
      end else if (col_end) begin
        row_d = row_q + {{(DIM_W-1){1'b0}}, 1'b1};
        col_d = '0;
      end else begin
        col_d = col_q + {{(DIM_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Position registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row = row_q;
  assign col = col_q;

endmodule

// File: rtl/matrix_unmake.sv
// Serialises an M x N matrix from the padded MAX_DIM x MAX_DIM layout as a
// row-major valid/ready element stream, and builds a compacted flat copy
// (element k = i*N+j at slot k) as beats are accepted.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for unmake; flat_out holds the previous result
//   STREAM  | presenting element (i,j); advances on each accepted beat
//   DONE    | one-cycle done pulse (with err on illegal dimensions)
module matrix_unmake
  import nm_matrix_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              unmake,
  input  logic [DIM_W-1:0]  m_dim,
  input  logic [DIM_W-1:0]  n_dim,
  input  logic [FLAT_W-1:0] matrix_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic [DIM_W-1:0]  row_idx,
  output logic [DIM_W-1:0]  col_idx,
  output logic              last,
  output logic [FLAT_W-1:0] flat_out,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_e            state_q;
  logic [DIM_W-1:0]  m_q;
  logic [DIM_W-1:0]  n_q;
  logic              valid_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic [FLAT_W-1:0] flat_q;

  logic [DIM_W-1:0]  row_w;
  logic [DIM_W-1:0]  col_w;
  logic              cnt_last;
  logic              cnt_clear;
  logic              cnt_adv;
  logic              accept;
  logic              dims_legal;
  logic [31:0]       m_ext;
  logic [31:0]       n_ext;
  logic [DATA_W-1:0] elem;

  // Dimension legality is checked at full 32-bit width so a DIM_W larger
  // than needed for MAX_DIM still rejects oversize values.
  assign m_ext      = 32'(m_dim);
  assign n_ext      = 32'(n_dim);
  assign dims_legal = (m_ext != 32'd0) && (n_ext != 32'd0) &&
                      (m_ext <= 32'(MAX_DIM)) && (n_ext <= 32'(MAX_DIM));

  assign accept    = valid_q && data_ready;
  assign cnt_clear = (state_q == ST_IDLE) && unmake && dims_legal;
  assign cnt_adv   = (state_q == ST_STREAM) && accept;

  matrix_idx_counter u_idx (
    .clk     (clk),
    .reset   (reset),
    .clear   (cnt_clear),
    .advance (cnt_adv),
    .m_dim   (m_q),
    .n_dim   (n_q),
    .row     (row_w),
    .col     (col_w),
    .last    (cnt_last)
  );

  // Source element is read from the padded layout (row stride MAX_DIM).
  assign elem = matrix_in[off(int'(row_w), int'(col_w), MAX_DIM) +: DATA_W];

  // Controller: state, registered handshake/status flags and the compacted copy.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      m_q     <= '0;
      n_q     <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      flat_q  <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (unmake) begin
            if (dims_legal) begin
              m_q     <= m_dim;
              n_q     <= n_dim;
              flat_q  <= '0;
              valid_q <= 1'b1;
              busy_q  <= 1'b1;
              state_q <= ST_STREAM;
            end else begin
              done_q  <= 1'b1;
              err_q   <= 1'b1;
              state_q <= ST_DONE;
            end
          end
        end
        ST_STREAM: begin
          if (accept) begin
            // Compacted layout uses the latched column count as row stride.
            flat_q[off(int'(row_w), int'(col_w), int'(n_q)) +: DATA_W] <= elem;
            if (cnt_last) begin
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Beat fields are forced to zero whenever no beat is being presented.
  assign data_out   = valid_q ? elem  : '0;
  assign row_idx    = valid_q ? row_w : '0;
  assign col_idx    = valid_q ? col_w : '0;
  assign last       = valid_q && cnt_last;
  assign data_valid = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign flat_out   = flat_q;

endmodule

// File: tb/tb_matrix_unmake.sv
// Scoreboard bench for matrix_unmake: stimulus pushes expected beats and
// done/err outcomes; a negedge monitor pops and compares as the DUT presents them.
module tb_matrix_unmake;
  import nm_matrix_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              unmake;
  logic [DIM_W-1:0]  m_dim;
  logic [DIM_W-1:0]  n_dim;
  logic [FLAT_W-1:0] matrix_in;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              data_ready;
  logic [DIM_W-1:0]  row_idx;
  logic [DIM_W-1:0]  col_idx;
  logic              last;
  logic [FLAT_W-1:0] flat_out;
  logic              busy;
  logic              done;
  logic              err;

  matrix_unmake dut (
    .clk        (clk),
    .reset      (reset),
    .unmake     (unmake),
    .m_dim      (m_dim),
    .n_dim      (n_dim),
    .matrix_in  (matrix_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .row_idx    (row_idx),
    .col_idx    (col_idx),
    .last       (last),
    .flat_out   (flat_out),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [DIM_W-1:0]  r;
    logic [DIM_W-1:0]  c;
    logic              l;
  } beat_t;

  beat_t exp_q[$];
  logic  exp_done_q[$];
  int    n_chk  = 0;
  int    n_pass = 0;
  int    pops   = 0;
  int    dones  = 0;
  beat_t cur;
  beat_t held;
  beat_t eb;
  logic  ee;
  bit    held_v = 1'b0;

  assign cur = {data_out, row_idx, col_idx, last};

  task automatic check(input bit ok, input string name,
                       input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [DATA_W-1:0] slot(input int k);
    return flat_out[k*DATA_W +: DATA_W];
  endfunction

  // Monitor: compare accepted beats, beat stability under backpressure, done/err.
  always @(negedge clk) begin
    if (reset) begin
      held_v = 1'b0;
    end else begin
      if (held_v && data_valid)
        check(cur == held, "hold_stable", 64'(cur), 64'(held));
      if (data_valid) begin
        if (data_ready) begin
          if (exp_q.size() == 0) begin
            check(1'b0, "unexpected_beat", 64'(cur), 64'd0);
          end else begin
            eb = exp_q.pop_front();
            check(cur == eb, "beat", 64'(cur), 64'(eb));
            pops++;
          end
          held_v = 1'b0;
        end else begin
          held_v = 1'b1;
          held   = cur;
        end
      end else begin
        held_v = 1'b0;
      end
      if (done) begin
        dones++;
        if (exp_done_q.size() == 0) begin
          check(1'b0, "unexpected_done", 64'(err), 64'd0);
        end else begin
          ee = exp_done_q.pop_front();
          check(err == ee, "done_err", 64'(err), 64'(ee));
          check(exp_q.size() == 0, "done_after_all_beats", 64'(exp_q.size()), 64'd0);
        end
      end else if (err) begin
        check(1'b0, "err_without_done", 64'(err), 64'd0);
      end
    end
  end

  task automatic set_el(input int i, input int j, input logic [DATA_W-1:0] v);
    matrix_in[off(i, j, MAX_DIM) +: DATA_W] = v;
  endtask

  task automatic push_mat(input int m, input int n);
    beat_t b;
    for (int i = 0; i < m; i++)
      for (int j = 0; j < n; j++) begin
        b.d = matrix_in[off(i, j, MAX_DIM) +: DATA_W];
        b.r = DIM_W'(i);
        b.c = DIM_W'(j);
        b.l = (i == m - 1) && (j == n - 1);
        exp_q.push_back(b);
      end
    exp_done_q.push_back(1'b0);
  endtask

  task automatic start(input int m, input int n, input bit exp_v);
    @(posedge clk); #1;
    m_dim  = DIM_W'(m);
    n_dim  = DIM_W'(n);
    unmake = 1'b1;
    @(posedge clk); #1;
    unmake = 1'b0;
    @(negedge clk);
    check(data_valid == exp_v, "first_valid_latency", 64'(data_valid), 64'(exp_v));
    if (!exp_v) check(done == 1'b1, "err_done_latency", 64'(done), 64'd1);
  endtask

  task automatic run(input int m, input int n, input bit exp_v,
                     input bit toggle, input bit inject);
    int d0;
    d0 = dones;
    start(m, n, exp_v);
    for (int k = 0; k < 300; k++) begin
      if (dones != d0) break;
      @(posedge clk); #1;
      if (toggle) data_ready = ((k % 3) == 0);
      if (inject && k == 1) begin
        unmake = 1'b1;
        m_dim  = 8'd1;
        n_dim  = 8'd1;
      end else begin
        unmake = 1'b0;
      end
    end
    check(dones == d0 + 1, "done_seen", 64'(dones - d0), 64'd1);
    check(exp_q.size() == 0, "beat_count", 64'(exp_q.size()), 64'd0);
    data_ready = 1'b1;
    unmake     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check(dones == d0 + 1, "single_done", 64'(dones - d0), 64'd1);
  endtask

  task automatic check_3x2_flat();
    for (int k = 0; k < 6; k++)
      check(slot(k) == DATA_W'(k + 1), $sformatf("flat_slot%0d", k),
            64'(slot(k)), 64'(k + 1));
    check(slot(6) == '0, "flat_slot6_zero", 64'(slot(6)), 64'd0);
  endtask

  initial begin
    int d0;
    int p0;
    reset      = 1'b1;
    unmake     = 1'b0;
    m_dim      = '0;
    n_dim      = '0;
    data_ready = 1'b1;
    matrix_in  = '0;
    repeat (3) @(posedge clk);
    #1;
    check(data_valid == 1'b0, "rst_valid", 64'(data_valid), 64'd0);
    check(busy == 1'b0, "rst_busy", 64'(busy), 64'd0);
    check(done == 1'b0 && err == 1'b0, "rst_done_err", 64'({done, err}), 64'd0);
    check(data_out == '0 && row_idx == '0 && col_idx == '0 && last == 1'b0,
          "rst_beat", 64'(cur), 64'd0);
    check(flat_out == '0, "rst_flat", flat_out[63:0], 64'd0);
    reset = 1'b0;

    // 3x2, elements 1..6, always ready
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 2; j++)
        set_el(i, j, DATA_W'(i * 2 + j + 1));
    push_mat(3, 2);
    run(3, 2, 1'b1, 1'b0, 1'b0);
    check_3x2_flat();

    // same 3x2 with backpressure 1,0,0 repeating
    push_mat(3, 2);
    run(3, 2, 1'b1, 1'b1, 1'b0);
    check_3x2_flat();

    // illegal dimensions: done+err, no beats, flat_out untouched
    exp_done_q.push_back(1'b1);
    run(0, 4, 1'b0, 1'b0, 1'b0);
    check_3x2_flat();
    exp_done_q.push_back(1'b1);
    run(129, 2, 1'b0, 1'b0, 1'b0);
    check_3x2_flat();

    // 1x1
    matrix_in = '0;
    set_el(0, 0, 32'hDEADBEEF);
    push_mat(1, 1);
    run(1, 1, 1'b1, 1'b0, 1'b0);
    check(slot(0) == 32'hDEADBEEF, "flat_1x1", 64'(slot(0)), 64'hDEADBEEF);
    check(slot(1) == '0, "flat_1x1_cleared", 64'(slot(1)), 64'd0);

    // unmake during STREAM ignored
    matrix_in = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 2; j++)
        set_el(i, j, DATA_W'(i * 2 + j + 1));
    push_mat(3, 2);
    run(3, 2, 1'b1, 1'b0, 1'b1);
    check_3x2_flat();

    // reset after beat 2 of a 3x3, then fresh restart
    matrix_in = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        set_el(i, j, DATA_W'(32'h100 + 16 * i + j));
    push_mat(3, 3);
    d0 = dones;
    p0 = pops;
    start(3, 3, 1'b1);
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      if (pops - p0 >= 2) break;
    end
    check(pops - p0 == 2, "beats_before_reset", 64'(pops - p0), 64'd2);
    reset      = 1'b1;
    data_ready = 1'b0;
    @(posedge clk); #1;
    check(data_valid == 1'b0 && busy == 1'b0, "midrst_valid_busy",
          64'({data_valid, busy}), 64'd0);
    check(done == 1'b0 && err == 1'b0, "midrst_done_err", 64'({done, err}), 64'd0);
    check(data_out == '0 && row_idx == '0 && col_idx == '0 && last == 1'b0,
          "midrst_beat", 64'(cur), 64'd0);
    check(flat_out == '0, "midrst_flat", flat_out[63:0], 64'd0);
    reset = 1'b0;
    exp_q.delete();
    exp_done_q.delete();
    data_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check(dones == d0, "no_done_after_reset", 64'(dones - d0), 64'd0);
    push_mat(3, 3);
    run(3, 3, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 9; k++)
      check(slot(k) == DATA_W'(32'h100 + 16 * (k / 3) + (k % 3)),
            $sformatf("flat3x3_slot%0d", k), 64'(slot(k)),
            64'(32'h100 + 16 * (k / 3) + (k % 3)));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
